// File: rtl/sd_data_serial_card_pkg.sv
// Shared definitions for the card-side SD 4-bit data-line engine:
// one-hot state encoding, bus/CRC sizes and CRC status tokens.
package sd_data_serial_card_pkg;

    localparam int          BUS_W             = 4;
    localparam int          CRC_LEN           = 16;
    localparam int          BLOCK_NIBBLES_DEF = 1024;
    localparam logic [15:0] CRC_POLY          = 16'h1021;  // x^16 + x^12 + x^5 + 1
    localparam logic [2:0]  TOKEN_OK          = 3'b010;
    localparam logic [2:0]  TOKEN_BAD         = 3'b101;

    typedef enum logic [12:0] {
        ST_IDLE     = 13'h0001,
        ST_RX_WAIT  = 13'h0002,
        ST_RX_DAT   = 13'h0004,
        ST_RX_CRC   = 13'h0008,
        ST_RX_END   = 13'h0010,
        ST_STAT_GAP = 13'h0020,
        ST_STAT     = 13'h0040,
        ST_BUSY     = 13'h0080,
        ST_TX_PRE   = 13'h0100,
        ST_TX_START = 13'h0200,
        ST_TX_DAT   = 13'h0400,
        ST_TX_CRC   = 13'h0800,
        ST_TX_END   = 13'h1000
    } state_t;

    // DAT0 value of the CRC status frame: start 0, three token bits, end 1.
    function automatic logic status_bit(input logic ok, input logic [2:0] idx);
        logic [2:0] tok;
        tok = ok ? TOKEN_OK : TOKEN_BAD;
        case (idx)
            3'd0:    return 1'b0;
            3'd1:    return tok[2];
            3'd2:    return tok[1];
            3'd3:    return tok[0];
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sd_crc_16.sv
// Serial CRC16 (x^16 + x^12 + x^5 + 1) for one SD DAT line; clr has
// priority over en and returns the register to zero.
module sd_crc_16
    import sd_data_serial_card_pkg::*;
(
    input  logic               sd_clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic               din,
    output logic [CRC_LEN-1:0] crc
);

    logic fb;

    assign fb = din ^ crc[CRC_LEN-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/sd_data_serial_card.sv
// Card-side SD 4-bit data engine: receives write blocks and answers with the
// CRC status token and busy, and transmits read blocks with per-line CRC16.
module sd_data_serial_card
    import sd_data_serial_card_pkg::*;
#(
    parameter int BLOCK_NIBBLES = BLOCK_NIBBLES_DEF,
    parameter int NAC_CYCLES    = 2,
    parameter int BUSY_CYCLES   = 8
) (
    input  logic             sd_clk,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] DAT_dat_i,
    output logic [BUS_W-1:0] DAT_dat_o,
    output logic             DAT_oe_o,
    input  logic             start_rx,
    input  logic             start_tx,
    input  logic             abort,
    output logic [31:0]      rx_data,
    output logic             rx_we,
    input  logic [31:0]      tx_data,
    output logic             tx_rd,
    output logic             busy,
    output logic             done,
    output logic             crc_ok
);

    localparam logic [10:0] LAST_NIB  = 11'(BLOCK_NIBBLES - 1);
    localparam logic [10:0] LAST_NAC  = 11'(NAC_CYCLES - 1);
    localparam logic [10:0] LAST_BUSY = 11'(BUSY_CYCLES);
    localparam logic [3:0]  LAST_CRC  = 4'(CRC_LEN - 1);

    state_t                          state, state_nxt;
    logic [10:0]                     nib_cnt;
    logic [3:0]                      crc_cnt;
    logic [31:0]                     word_sr;
    logic [BUS_W-1:0][CRC_LEN-1:0]   rx_crc;
    logic [CRC_LEN-1:0]              crc_q [BUS_W];
    logic [BUS_W-1:0]                crc_din;
    logic                            crc_clr, crc_en, crc_match, last_nib;

    assign busy     = (state != ST_IDLE);
    assign rx_data  = word_sr;
    assign last_nib = (nib_cnt == LAST_NIB);
    assign crc_clr  = state inside {ST_IDLE, ST_RX_WAIT, ST_TX_PRE};
    assign crc_en   = state inside {ST_RX_DAT, ST_TX_DAT};
    assign crc_din  = (state == ST_RX_DAT) ? DAT_dat_i : word_sr[31:28];

    for (genvar i = 0; i < BUS_W; i++) begin : g_crc
        sd_crc_16 u_crc (
            .sd_clk (sd_clk),
            .rst_n  (rst_n),
            .clr    (crc_clr),
            .en     (crc_en),
            .din    (crc_din[i]),
            .crc    (crc_q[i])
        );
    end

    always_comb begin
        crc_match = 1'b1;
        for (int i = 0; i < BUS_W; i++) begin
            if (rx_crc[i] != crc_q[i]) crc_match = 1'b0;
        end
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        DAT_dat_o = 4'hF;
        DAT_oe_o  = 1'b0;
        tx_rd     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_rx)      state_nxt = ST_RX_WAIT;
                else if (start_tx) state_nxt = (NAC_CYCLES == 0) ? ST_TX_START : ST_TX_PRE;
            end
            ST_RX_WAIT:  if (!DAT_dat_i[0]) state_nxt = ST_RX_DAT;
            ST_RX_DAT:   if (last_nib) state_nxt = ST_RX_CRC;
            ST_RX_CRC:   if (crc_cnt == LAST_CRC) state_nxt = ST_RX_END;
            ST_RX_END:   state_nxt = ST_STAT_GAP;
            ST_STAT_GAP: if (nib_cnt == 11'd1) state_nxt = ST_STAT;
            ST_STAT: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = {3'b111, status_bit(crc_ok, nib_cnt[2:0])};
                if (nib_cnt == 11'd4) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = (nib_cnt == LAST_BUSY) ? 4'hF : 4'hE;
                if (nib_cnt == LAST_BUSY) state_nxt = ST_IDLE;
            end
            ST_TX_PRE: begin
                DAT_oe_o = 1'b1;
                if (nib_cnt == LAST_NAC) state_nxt = ST_TX_START;
            end
            ST_TX_START: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = 4'h0;
                tx_rd     = 1'b1;
                state_nxt = ST_TX_DAT;
            end
            ST_TX_DAT: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = word_sr[31:28];
                // The last nibble of each word is on the bus while the next word is popped.
                tx_rd     = (nib_cnt[2:0] == 3'd7) && !last_nib;
                if (last_nib) state_nxt = ST_TX_CRC;
            end
            ST_TX_CRC: begin
                DAT_oe_o = 1'b1;
                for (int i = 0; i < BUS_W; i++) DAT_dat_o[i] = crc_q[i][LAST_CRC - crc_cnt];
                if (crc_cnt == LAST_CRC) state_nxt = ST_TX_END;
            end
            ST_TX_END: begin
                DAT_oe_o  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            tx_rd     = 1'b0;
        end
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_cnt <= '0;
            crc_cnt <= '0;
            word_sr <= '0;
            rx_crc  <= '0;
            rx_we   <= 1'b0;
            done    <= 1'b0;
            crc_ok  <= 1'b0;
        end else begin
            rx_we <= 1'b0;
            done  <= 1'b0;
            // Both counters restart on every state change, so each phase counts from 0.
            if (state_nxt != state || state inside {ST_IDLE, ST_RX_WAIT}) nib_cnt <= '0;
            else                                                          nib_cnt <= nib_cnt + 11'd1;
            if (state_nxt != state || !(state inside {ST_RX_CRC, ST_TX_CRC})) crc_cnt <= '0;
            else                                                              crc_cnt <= crc_cnt + 4'd1;
            if (!abort) begin
                case (state)
                    ST_RX_WAIT: if (!DAT_dat_i[0]) crc_ok <= 1'b0;
                    ST_RX_DAT: begin
                        word_sr <= {word_sr[27:0], DAT_dat_i};
                        rx_we   <= (nib_cnt[2:0] == 3'd7);
                    end
                    ST_RX_CRC: begin
                        for (int i = 0; i < BUS_W; i++) rx_crc[i] <= {rx_crc[i][CRC_LEN-2:0], DAT_dat_i[i]};
                    end
                    ST_RX_END:   crc_ok  <= crc_match && (DAT_dat_i == 4'hF);
                    ST_BUSY:     done    <= (nib_cnt == LAST_BUSY);
                    ST_TX_START: word_sr <= tx_data;
                    ST_TX_DAT:   word_sr <= tx_rd ? tx_data : {word_sr[27:0], 4'h0};
                    ST_TX_END:   done    <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_data_serial_card.sv
// Scoreboard bench for sd_data_serial_card: host-side write/read model with
// a reference CRC16, expected words/bus values queued and popped per cycle.
module tb_sd_data_serial_card;

    localparam int NIBS  = 1024;
    localparam int WORDS = NIBS / 8;
    localparam int NAC   = 2;
    localparam int BUSYC = 8;

    logic        sd_clk = 1'b0;
    logic        rst_n  = 1'b1;
    logic [3:0]  DAT_dat_i = 4'hF;
    logic [3:0]  DAT_dat_o;
    logic        DAT_oe_o;
    logic        start_rx = 1'b0, start_tx = 1'b0, abort = 1'b0;
    logic [31:0] rx_data;
    logic        rx_we;
    logic [31:0] tx_data;
    logic        tx_rd, busy, done, crc_ok;

    always #5 sd_clk = ~sd_clk;

    sd_data_serial_card #(
        .BLOCK_NIBBLES (NIBS),
        .NAC_CYCLES    (NAC),
        .BUSY_CYCLES   (BUSYC)
    ) dut (
        .sd_clk    (sd_clk),
        .rst_n     (rst_n),
        .DAT_dat_i (DAT_dat_i),
        .DAT_dat_o (DAT_dat_o),
        .DAT_oe_o  (DAT_oe_o),
        .start_rx  (start_rx),
        .start_tx  (start_tx),
        .abort     (abort),
        .rx_data   (rx_data),
        .rx_we     (rx_we),
        .tx_data   (tx_data),
        .tx_rd     (tx_rd),
        .busy      (busy),
        .done      (done),
        .crc_ok    (crc_ok)
    );

    // Show-ahead FIFO model: word n holds the value n.
    logic        fifo_rst = 1'b1;
    logic [31:0] rd_ptr;
    always @(posedge sd_clk) begin
        if (fifo_rst)   rd_ptr <= 32'd0;
        else if (tx_rd) rd_ptr <= rd_ptr + 32'd1;
    end
    assign tx_data = rd_ptr;

    int          n_cmp = 0, n_bad = 0, done_cnt = 0;
    logic [31:0] rx_exp_q [$];
    logic        s_oe, s_done, s_busy, s_rx_we, s_crc_ok;
    logic [3:0]  s_dat;
    logic [31:0] s_rx_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Sample outputs of the current cycle at the falling edge, then move past the next rising edge.
    task automatic next_cycle();
        @(negedge sd_clk);
        s_oe = DAT_oe_o; s_dat = DAT_dat_o; s_done = done; s_busy = busy;
        s_rx_we = rx_we; s_rx_data = rx_data; s_crc_ok = crc_ok;
        if (s_done) done_cnt++;
        if (s_rx_we) begin
            if (rx_exp_q.size() == 0) check("rx_extra_we", 32'(s_rx_we), 32'd0);
            else                      check("rx_word", s_rx_data, rx_exp_q.pop_front());
        end
        @(posedge sd_clk);
        #1;
    endtask

    task automatic write_block(input bit do_start, input logic [15:0] flip2, input int abort_at, input bit exp_ok);
        logic [15:0] hc [4];
        logic [31:0] w;
        logic [3:0]  nib;
        logic [4:0]  tok_seq;
        int          done0;
        for (int i = 0; i < 4; i++) hc[i] = 16'h0;
        w = 32'h0123_4567;
        if (do_start) begin start_rx = 1'b1; next_cycle(); start_rx = 1'b0; end
        DAT_dat_i = 4'hF; next_cycle(); next_cycle();
        DAT_dat_i = 4'h0; next_cycle();
        for (int k = 0; k < NIBS; k++) begin
            if (k == abort_at) begin
                abort = 1'b1; DAT_dat_i = 4'hF; next_cycle(); abort = 1'b0;
                done0 = done_cnt;
                next_cycle();
                check("abort_oe", 32'(s_oe), 32'd0);
                check("abort_busy", 32'(s_busy), 32'd0);
                check("abort_crc_ok", 32'(s_crc_ok), 32'd0);
                repeat (20) next_cycle();
                check("abort_done", 32'(done_cnt - done0), 32'd0);
                check("abort_rx_left", 32'(rx_exp_q.size()), 32'd0);
                return;
            end
            nib = w[31 - 4*(k%8) -: 4];
            DAT_dat_i = nib;
            for (int i = 0; i < 4; i++) hc[i] = crc16_step(hc[i], nib[i]);
            if (k % 8 == 7) rx_exp_q.push_back(w);
            next_cycle();
        end
        hc[2] = hc[2] ^ flip2;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) DAT_dat_i[i] = hc[i][15-k];
            next_cycle();
        end
        DAT_dat_i = 4'hF; next_cycle();
        done0   = done_cnt;
        tok_seq = {1'b0, (exp_ok ? 3'b010 : 3'b101), 1'b1};
        repeat (2) begin next_cycle(); check("wr_gap_oe", 32'(s_oe), 32'd0); end
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            check("wr_tok_oe", 32'(s_oe), 32'd1);
            check("wr_tok_dat0", 32'(s_dat[0]), 32'(tok_seq[4-k]));
            check("wr_tok_dat321", 32'(s_dat[3:1]), 32'd7);
        end
        for (int k = 0; k < BUSYC; k++) begin
            next_cycle();
            check("wr_busy_oe_dat0", 32'({s_oe, s_dat[0]}), 32'd2);
        end
        next_cycle(); check("wr_release", 32'({s_oe, s_dat}), 32'h1F);
        next_cycle();
        check("wr_idle_oe", 32'(s_oe), 32'd0);
        check("wr_done", 32'(s_done), 32'd1);
        check("wr_crc_ok", 32'(s_crc_ok), 32'(exp_ok));
        next_cycle();
        check("wr_done_pulses", 32'(done_cnt - done0), 32'd1);
        check("wr_rx_left", 32'(rx_exp_q.size()), 32'd0);
    endtask

    task automatic read_block(input int reset_at);
        logic [4:0]  exp_q [$];
        logic [4:0]  e;
        logic [15:0] c [4];
        logic [31:0] w;
        logic [3:0]  nib;
        int          done0;
        fifo_rst = 1'b1; next_cycle(); fifo_rst = 1'b0;
        for (int i = 0; i < 4; i++) c[i] = 16'h0;
        repeat (NAC) exp_q.push_back(5'h1F);
        exp_q.push_back(5'h10);
        for (int k = 0; k < NIBS; k++) begin
            w   = 32'(k / 8);
            nib = w[31 - 4*(k%8) -: 4];
            exp_q.push_back({1'b1, nib});
            for (int i = 0; i < 4; i++) c[i] = crc16_step(c[i], nib[i]);
        end
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) nib[i] = c[i][15-k];
            exp_q.push_back({1'b1, nib});
        end
        exp_q.push_back(5'h1F);
        done0 = done_cnt;
        start_tx = 1'b1; next_cycle(); start_tx = 1'b0;
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (k == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_oe", 32'(DAT_oe_o), 32'd0);
                check("rst_mid_dat", 32'(DAT_dat_o), 32'hF);
                check("rst_mid_tx_rd", 32'(tx_rd), 32'd0);
                check("rst_mid_busy", 32'(busy), 32'd0);
                check("rst_mid_crc_ok", 32'(crc_ok), 32'd0);
                next_cycle();
                rst_n = 1'b1;
                next_cycle();
                check("rst_rel_busy", 32'(s_busy), 32'd0);
                check("rst_rel_oe", 32'(s_oe), 32'd0);
                return;
            end
            next_cycle();
            e = exp_q.pop_front();
            check("rd_bus", 32'({s_oe, s_dat}), 32'(e));
        end
        next_cycle();
        check("rd_idle_oe", 32'(s_oe), 32'd0);
        check("rd_done", 32'(s_done), 32'd1);
        next_cycle();
        check("rd_done_pulses", 32'(done_cnt - done0), 32'd1);
        check("rd_pops", rd_ptr, 32'(WORDS));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_oe", 32'(DAT_oe_o), 32'd0);
        check("rst_dat", 32'(DAT_dat_o), 32'hF);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_rx_we", 32'(rx_we), 32'd0);
        check("rst_tx_rd", 32'(tx_rd), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_crc_ok", 32'(crc_ok), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        next_cycle(); next_cycle();
        rst_n = 1'b1; fifo_rst = 1'b0;
        next_cycle();

        write_block(1'b1, 16'h0000, -1, 1'b1);
        write_block(1'b1, 16'h0020, -1, 1'b0);
        read_block(-1);

        start_rx = 1'b1; start_tx = 1'b1; next_cycle();
        start_rx = 1'b0; start_tx = 1'b0;
        DAT_dat_i = 4'b0001;
        repeat (5) begin
            next_cycle();
            check("dual_oe", 32'(s_oe), 32'd0);
            check("dual_busy", 32'(s_busy), 32'd1);
        end
        write_block(1'b0, 16'h0000, -1, 1'b1);

        write_block(1'b1, 16'h0000, 300, 1'b0);
        write_block(1'b1, 16'h0000, -1, 1'b1);

        read_block(100);
        read_block(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sd_data_serial_card.md
Name: sd_data_serial_card

Overview:
Card-side 4-bit SD data-line engine, the counterpart of the host data serializer. It receives host write blocks and returns the CRC status token and busy signal. It sends read blocks to the host: start bit, data, per-line CRC16, end bit. It is used as the data path of the synthesizable SD card model and card-emulation targets, and sits between the DAT[3:0] pad tristate and card-side block FIFOs.

Parameters:
BLOCK_NIBBLES, 1024, data nibbles per block (512 bytes on 4 lines); must be a multiple of 8.
NAC_CYCLES, 2, idle-high cycles (oe=1, 4'b1111) after start_tx and before the read start bit; 0 allowed.
BUSY_CYCLES, 8, cycles DAT0 is held low after the status token; minimum 1.

Ports:
sd_clk  in  1  SD bus clock; all logic on posedge.
rst_n  in  1  async active-low reset.
DAT_dat_i  in  4  sampled DAT lines.
DAT_dat_o  out  4  driven DAT value.
DAT_oe_o  out  1  DAT tristate enable.
start_rx  in  1  IDLE-only: arm to receive one write block.
start_tx  in  1  IDLE-only: send one read block.
abort  in  1  return to IDLE from any state.
rx_data  out  32  assembled write word; first received nibble in [31:28].
rx_we  out  1  1-cycle strobe; rx_data valid.
tx_data  in  32  show-ahead FIFO head; first sent nibble is [31:28].
tx_rd  out  1  1-cycle pop; tx_data captured on that same edge.
busy  out  1  state != IDLE.
done  out  1  1-cycle pulse on normal completion of rx or tx.
crc_ok  out  1  result of last received block; held until next start_rx.

Behaviour:
- Reset: DAT_oe_o=0, DAT_dat_o=4'b1111, rx_data=0, rx_we=0, tx_rd=0, done=0, crc_ok=0, state IDLE. Counters and CRCs cleared.
- States: IDLE, RX_WAIT, RX_DAT, RX_CRC, RX_END, STAT_GAP, STAT, BUSY, TX_PRE, TX_START, TX_DAT, TX_CRC, TX_END.
- IDLE:
  - oe=0, CRC generators held in reset.
  - start_rx -> RX_WAIT; start_tx -> TX_PRE (or TX_START if NAC_CYCLES=0).
  - Both high: start_rx wins.
- RX_WAIT: DAT_dat_i[0]==0 sampled -> RX_DAT; nibble count = 0; crc_ok cleared. DAT1..3 alone never start a block.
- RX_DAT:
  - Each cycle: sample a nibble, feed line i to CRC i, shift into the word register MSB-first.
  - After every 8th nibble: rx_we=1 next cycle with the completed word. Exactly BLOCK_NIBBLES/8 strobes per block.
  - After the last nibble -> RX_CRC.
- RX_CRC: 16 cycles; shift the received CRC per line MSB-first -> RX_END.
- RX_END:
  - Sample the end bit.
  - crc_ok = (received CRC == computed CRC on all 4 lines) && end nibble == 4'b1111.
  - -> STAT_GAP.
- STAT_GAP: 2 cycles, oe=0.
- STAT: 5 cycles, oe=1, DAT[3:1]=1. DAT0 sequence is 0, s2, s1, s0, 1, where s = 3'b010 if crc_ok else 3'b101.
- BUSY:
  - DAT0=0, oe=1 for BUSY_CYCLES cycles.
  - Then one cycle DAT=4'b1111, oe=1.
  - Then oe=0, done pulse, IDLE.
- TX_PRE: NAC_CYCLES cycles, oe=1, DAT=4'b1111.
- TX_START: one cycle, DAT=4'b0000, oe=1, tx_rd=1 (capture word 0).
- TX_DAT:
  - BLOCK_NIBBLES cycles; drive the word [31:28] first, feeding CRCs with the driven nibble.
  - tx_rd pulses on the edge that drives the last nibble of each word, except the final word. Total pops = BLOCK_NIBBLES/8.
- TX_CRC: 16 cycles, line i drives CRC i MSB first.
- TX_END: DAT=4'b1111 one cycle; then oe=0, done pulse, IDLE.
- abort:
  - Highest priority in any state: IDLE next edge, oe=0, DAT_dat_o=4'b1111.
  - rx_we, tx_rd and done are not asserted on that edge; crc_ok is unchanged.
- start_rx/start_tx outside IDLE are ignored.
- Nibble counter: 11 bits; wrap is impossible by construction. The CRC phase uses a separate 4-bit counter.
- tx_data underflow is not detected; the FIFO owner guarantees data.

Decomposition:
- Shared defines/package: state encoding (one-hot, 13 bits), BLOCK_NIBBLES default, CRC length 16, status tokens 3'b010 and 3'b101, bus width 4.
- Sub-module: the existing sd_crc_16 (x^16+x^12+x^5+1), instantiated 4 times via generate. Reset it in IDLE/RX_WAIT/TX_PRE; enable it only during RX_DAT/TX_DAT.

Test Plan:
- Write of words 0x01234567 ×128 with correct CRCs -> 128 rx_we each 0x01234567, DAT0 token 0,0,1,0,1, DAT0 low 8 cycles, crc_ok=1, one done pulse.
- Same block with CRC bit 5 of line 2 flipped -> token 0,1,0,1,1, crc_ok=0, busy phase still 8 cycles, done pulses.
- start_tx with FIFO words 0..127 -> 2 cycles of 4'hF, start nibble 0, then nibbles 0,0,…,0,1,… and 128 tx_rd pulses. Per-line CRCs equal a reference CRC16 model; end 4'hF; oe drops; done.
- abort at RX_DAT nibble 300 -> oe=0 next edge, state IDLE, no further rx_we, no done, crc_ok unchanged; next start_rx works normally.
- DAT1=0 while DAT0=1 in RX_WAIT -> stays in RX_WAIT; start_rx and start_tx on the same cycle -> RX_WAIT entered, DAT_oe_o stays 0.
- Reset asserted mid-TX_DAT -> outputs immediately at reset values; after release, busy=0 and a new start_tx yields a correct block.
